// File: rtl/tacky_fetch_ctrl.sv
// tacky_fetch_ctrl: instruction fetch and sequencing stage for the Tacky core.
// Owns the architectural PC and the 8-bit `pre` prefix register, fetches one
// 16-bit word at a time, splits it into a full-word instruction or two packed
// 8-bit slots, issues them to execute, and resolves jumps/pre/sys locally by
// steering the downstream `counter` next-PC block.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr, imem_ack/data  instruction memory fetch handshake
//   iss_valid/ready, iss_op/reg/imm  issue handshake towards execute
//   rd_a, rd_b                 register file read addresses (counter reg1/reg2)
//   pc, cnt_imm, cnt_ctl       operands and control for the counter block
//   new_pc                     counter result, loaded into pc at NEXT
//   halted                     `sys` reached, sticky until reset
module tacky_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        iss_valid,
    input  logic        iss_ready,
    output logic [4:0]  iss_op,
    output logic [2:0]  iss_reg,
    output logic [15:0] iss_imm,
    output logic [2:0]  rd_a,
    output logic [2:0]  rd_b,
    output logic [15:0] pc,
    output logic [15:0] cnt_imm,
    output logic [3:0]  cnt_ctl,
    input  logic [15:0] new_pc,
    output logic        halted
);

    localparam int unsigned PC_W  = 16;
    localparam int unsigned PRE_W = 8;
    localparam int unsigned OP_W  = 5;

    localparam logic [OP_W-1:0] OP_JR   = 5'h0A;
    localparam logic [OP_W-1:0] OP_JNZ8 = 5'h19;
    localparam logic [OP_W-1:0] OP_JZ8  = 5'h1A;
    localparam logic [OP_W-1:0] OP_JP8  = 5'h1B;
    localparam logic [OP_W-1:0] OP_CF8  = 5'h1C;
    localparam logic [OP_W-1:0] OP_CI8  = 5'h1D;
    localparam logic [OP_W-1:0] OP_PRE  = 5'h1E;
    localparam logic [OP_W-1:0] OP_SYS  = 5'h1F;

    localparam logic [3:0] CTL_INC  = 4'h0;
    localparam logic [3:0] CTL_JZ   = 4'h1;
    localparam logic [3:0] CTL_JNZ  = 4'h2;
    localparam logic [3:0] CTL_JP   = 4'h3;
    localparam logic [3:0] CTL_REGA = 4'h8;
    localparam logic [3:0] CTL_REGB = 4'hC;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_SLOT_HI = 3'd1,
        ST_SLOT_LO = 3'd2,
        ST_NEXT    = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [PC_W-1:0]   word_q, word_d;

    // Word decode, purely from the latched word
    logic            full_w;
    logic [OP_W-1:0] op_hi;
    logic [OP_W-1:0] op_lo;
    logic            imm_op;
    logic            hi_jr;
    logic            lo_jr;

    assign full_w = (word_q[15:14] == 2'b11);
    assign op_hi  = word_q[15:11];
    assign op_lo  = word_q[7:3];
    assign imm_op = full_w && ((op_hi == OP_CI8) || (op_hi == OP_CF8));
    assign hi_jr  = !full_w && (op_hi == OP_JR);
    assign lo_jr  = !full_w && (op_lo == OP_JR);

    // Datapath outputs that are plain views of architectural state
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign rd_a      = word_q[10:8];
    assign rd_b      = word_q[2:0];
    assign cnt_imm   = {pre_q, word_q[7:0]};

    // State and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            pre_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pre_q   <= pre_d;
            word_q  <= word_d;
        end
    end

    // Next-state and output decode; handshake inputs only steer the next state
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pre_d     = pre_q;
        word_d    = word_q;
        imem_req  = 1'b0;
        iss_valid = 1'b0;
        iss_op    = '0;
        iss_reg   = '0;
        iss_imm   = '0;
        cnt_ctl   = CTL_INC;
        halted    = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    word_d  = imem_data;
                    state_d = ST_SLOT_HI;
                end
            end

            ST_SLOT_HI: begin
                if (full_w) begin
                    if (imm_op) begin
                        iss_valid = 1'b1;
                        iss_op    = op_hi;
                        iss_reg   = word_q[10:8];
                        iss_imm   = {pre_q, word_q[7:0]};
                        if (iss_ready) state_d = ST_NEXT;
                    end else if (op_hi == OP_SYS) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else if (hi_jr) begin
                    state_d = ST_NEXT;
                end else begin
                    iss_valid = 1'b1;
                    iss_op    = op_hi;
                    iss_reg   = word_q[10:8];
                    // A jr in the LO slot is never issued, so skip straight on
                    if (iss_ready) state_d = lo_jr ? ST_NEXT : ST_SLOT_LO;
                end
            end

            ST_SLOT_LO: begin
                if (lo_jr) begin
                    state_d = ST_NEXT;
                end else begin
                    iss_valid = 1'b1;
                    iss_op    = op_lo;
                    iss_reg   = word_q[2:0];
                    if (iss_ready) state_d = ST_NEXT;
                end
            end

            ST_NEXT: begin
                if (full_w) begin
                    unique case (op_hi)
                        OP_JZ8:  cnt_ctl = CTL_JZ;
                        OP_JNZ8: cnt_ctl = CTL_JNZ;
                        OP_JP8:  cnt_ctl = CTL_JP;
                        default: cnt_ctl = CTL_INC;
                    endcase
                    // pre only survives into the instruction right after it
                    if (op_hi == OP_PRE) begin
                        pre_d = word_q[7:0];
                    end else if ((op_hi == OP_JZ8) || (op_hi == OP_JNZ8) ||
                                 (op_hi == OP_JP8) || imm_op) begin
                        pre_d = '0;
                    end
                end else if (hi_jr) begin
                    cnt_ctl = CTL_REGA;
                end else if (lo_jr) begin
                    cnt_ctl = CTL_REGB;
                end
                pc_d    = new_pc;
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_tacky_fetch_ctrl.sv
// Self-checking bench for tacky_fetch_ctrl: a word-level reference model
// predicts, per fetched word, the cycle sequence of issues, the NEXT-cycle
// counter controls and the resulting pc/pre, and every cycle is compared.
module tb_tacky_fetch_ctrl;

    localparam logic [15:0] RESET_PC = 16'h0000;

    localparam int K_ISSUE = 0;
    localparam int K_IDLE  = 1;
    localparam int K_NEXT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        iss_valid;
    logic        iss_ready = 1'b0;
    logic [4:0]  iss_op;
    logic [2:0]  iss_reg;
    logic [15:0] iss_imm;
    logic [2:0]  rd_a;
    logic [2:0]  rd_b;
    logic [15:0] pc;
    logic [15:0] cnt_imm;
    logic [3:0]  cnt_ctl;
    logic [15:0] new_pc = 16'h0;
    logic        halted;

    tacky_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_reg(iss_reg), .iss_imm(iss_imm),
        .rd_a(rd_a), .rd_b(rd_b), .pc(pc),
        .cnt_imm(cnt_imm), .cnt_ctl(cnt_ctl), .new_pc(new_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [4:0]  op;
        logic [2:0]  rg;
        logic [15:0] imm;
        logic [3:0]  ctl;
        logic [15:0] cimm;
        logic [15:0] npc;
        logic [7:0]  npre;
        bit          halt;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment: instruction memory and register file
    logic [15:0] mem [logic [15:0]];
    logic [15:0] regs [8];

    // Reference model state
    logic [15:0] m_pc;
    logic [7:0]  m_pre;
    bit          m_halted;
    exp_t        exp_q[$];
    int          words_done = 0;

    // Stimulus controls
    bit force_ack   = 1'b0;
    bit force_ready = 1'b0;
    int stall_left  = 0;

    // Observations for the hand-computed directed checks
    logic [4:0]  obs_op[$];
    logic [2:0]  obs_reg[$];
    logic [15:0] obs_imm[$];
    logic [3:0]  obs_ctl;
    logic [15:0] obs_cimm;
    logic [2:0]  obs_rda;
    logic [2:0]  obs_rdb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        forever begin
            w = 16'($urandom);
            if (w[15:11] == 5'h18) continue;
            if (w[15:11] == 5'h1F && $urandom_range(0, 15) != 0) continue;
            return w;
        end
    endfunction

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = rand_word();
        return mem[a];
    endfunction

    // Downstream counter block, driven from the DUT's own control outputs
    function automatic logic [15:0] counter(input logic [3:0] ctl, input logic [15:0] p,
                                            input logic [15:0] imm, input logic [2:0] a,
                                            input logic [2:0] b);
        case (ctl)
            4'h1:    return (regs[a] == 16'h0) ? imm : 16'(p + 16'd1);
            4'h2:    return (regs[a] != 16'h0) ? imm : 16'(p + 16'd1);
            4'h3:    return imm;
            4'h8:    return regs[a];
            4'hC:    return regs[b];
            default: return 16'(p + 16'd1);
        endcase
    endfunction

    function automatic exp_t mk(input int kind);
        exp_t e;
        e.kind = kind; e.op = '0; e.rg = '0; e.imm = '0; e.ctl = '0;
        e.cimm = '0; e.npc = '0; e.npre = '0; e.halt = 1'b0;
        return e;
    endfunction

    // Expected cycle sequence after a word is accepted
    task automatic build(input logic [15:0] w);
        exp_t e;
        exp_t n;
        logic [4:0]  oh = w[15:11];
        logic [4:0]  ol = w[7:3];
        logic [15:0] inc = 16'(m_pc + 16'd1);
        logic [15:0] imm = {m_pre, w[7:0]};
        n = mk(K_NEXT);
        n.cimm = imm; n.npc = inc; n.npre = m_pre; n.ctl = 4'h0;
        if (w[15:14] == 2'b11) begin
            if (oh == 5'h1C || oh == 5'h1D) begin
                e = mk(K_ISSUE); e.op = oh; e.rg = w[10:8]; e.imm = imm;
                exp_q.push_back(e);
                n.npre = 8'h0;
                exp_q.push_back(n);
            end else if (oh == 5'h1F) begin
                e = mk(K_IDLE); e.halt = 1'b1;
                exp_q.push_back(e);
            end else begin
                exp_q.push_back(mk(K_IDLE));
                if (oh == 5'h1E) n.npre = w[7:0];
                if (oh == 5'h19 || oh == 5'h1A || oh == 5'h1B) n.npre = 8'h0;
                if (oh == 5'h1A) begin n.ctl = 4'h1; n.npc = (regs[w[10:8]] == 0) ? imm : inc; end
                if (oh == 5'h19) begin n.ctl = 4'h2; n.npc = (regs[w[10:8]] != 0) ? imm : inc; end
                if (oh == 5'h1B) begin n.ctl = 4'h3; n.npc = imm; end
                exp_q.push_back(n);
            end
        end else if (oh == 5'h0A) begin
            exp_q.push_back(mk(K_IDLE));
            n.ctl = 4'h8; n.npc = regs[w[10:8]];
            exp_q.push_back(n);
        end else begin
            e = mk(K_ISSUE); e.op = oh; e.rg = w[10:8];
            exp_q.push_back(e);
            if (ol == 5'h0A) begin
                n.ctl = 4'hC; n.npc = regs[w[2:0]];
            end else begin
                e = mk(K_ISSUE); e.op = ol; e.rg = w[2:0];
                exp_q.push_back(e);
            end
            exp_q.push_back(n);
        end
    endtask

    // One clock: compare DUT against the model, then drive the next inputs
    task automatic step();
        exp_t e;
        @(negedge clk);
        new_pc    = 16'($urandom);
        iss_ready = 1'($urandom);
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        if (exp_q.size() == 0) begin
            if (m_halted) begin
                chk("halt_halted", halted, 1);
                chk("halt_req", imem_req, 0);
                chk("halt_valid", iss_valid, 0);
                chk("halt_ctl", cnt_ctl, 0);
            end else begin
                chk("fetch_req", imem_req, 1);
                chk("fetch_addr", imem_addr, m_pc);
                chk("fetch_pc", pc, m_pc);
                chk("fetch_valid", iss_valid, 0);
                chk("fetch_halted", halted, 0);
                if (force_ack || $urandom_range(0, 2) != 0) begin
                    imem_ack  = 1'b1;
                    imem_data = mem_word(m_pc);
                    build(imem_data);
                end
            end
        end else begin
            e = exp_q[0];
            if (e.kind == K_ISSUE) begin
                chk("iss_valid", iss_valid, 1);
                chk("iss_op", iss_op, e.op);
                chk("iss_reg", iss_reg, e.rg);
                chk("iss_imm", iss_imm, e.imm);
                chk("iss_req", imem_req, 0);
                if (stall_left > 0) begin
                    iss_ready = 1'b0;
                    stall_left--;
                end else begin
                    iss_ready = force_ready ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                end
                if (iss_ready) begin
                    obs_op.push_back(iss_op);
                    obs_reg.push_back(iss_reg);
                    obs_imm.push_back(iss_imm);
                    void'(exp_q.pop_front());
                end
            end else if (e.kind == K_IDLE) begin
                chk("idle_valid", iss_valid, 0);
                chk("idle_req", imem_req, 0);
                chk("idle_halted", halted, 0);
                void'(exp_q.pop_front());
                if (e.halt) m_halted = 1'b1;
            end else begin
                chk("next_valid", iss_valid, 0);
                chk("next_req", imem_req, 0);
                chk("next_ctl", cnt_ctl, e.ctl);
                chk("next_cimm", cnt_imm, e.cimm);
                chk("next_pc", pc, m_pc);
                new_pc   = counter(cnt_ctl, pc, cnt_imm, rd_a, rd_b);
                obs_ctl  = cnt_ctl;
                obs_cimm = cnt_imm;
                obs_rda  = rd_a;
                obs_rdb  = rd_b;
                void'(exp_q.pop_front());
                m_pc  = e.npc;
                m_pre = e.npre;
                words_done++;
            end
        end
    endtask

    task automatic clr_obs();
        obs_op.delete(); obs_reg.delete(); obs_imm.delete();
        obs_ctl = 'x; obs_cimm = 'x; obs_rda = 'x; obs_rdb = 'x;
    endtask

    // Run until the current word reaches NEXT or halts, counting cycles
    task automatic run_word(output int cycles);
        int start = words_done;
        cycles = 0;
        clr_obs();
        while (words_done == start && !m_halted && cycles < 64) begin
            step();
            cycles++;
        end
        if (cycles >= 64) begin
            n_tests++; n_fail++;
            $display("FAIL run_word_timeout: got %0d cycles expected < 64", cycles);
        end
    endtask

    task automatic pc_after(input string name, input logic [15:0] exp);
        @(posedge clk);
        #1;
        chk(name, pc, exp);
    endtask

    // Asynchronous reset mid-cycle with an ack in flight
    task automatic do_reset();
        @(negedge clk);
        imem_ack  = 1'b1;
        imem_data = 16'hF800;
        iss_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", imem_req, 1);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_valid", iss_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ctl", cnt_ctl, 0);
        @(negedge clk);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        m_pc = RESET_PC; m_pre = 8'h0; m_halted = 1'b0;
        exp_q.delete();
        stall_left = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < 8; i++) regs[i] = 16'(16'h1111 * (i + 1));
        m_pc = RESET_PC; m_pre = 8'h0; m_halted = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        force_ack = 1'b1; force_ready = 1'b1;

        // Packed word, two issues
        mem[16'h0000] = 16'h210A;
        run_word(c);
        chk("p2_cycles", c, 4);
        chk("p2_nissue", obs_op.size(), 2);
        if (obs_op.size() == 2) begin
            chk("p2_op0", obs_op[0], 5'h04);  chk("p2_reg0", obs_reg[0], 3'd1);
            chk("p2_op1", obs_op[1], 5'h01);  chk("p2_reg1", obs_reg[1], 3'd2);
        end
        chk("p2_ctl", obs_ctl, 4'h0);
        pc_after("p2_pc", 16'h0001);

        // jp8 to 5, then pre + jp8 to 0x1234
        mem[16'h0001] = 16'hD805;
        run_word(c);
        chk("jp5_ctl", obs_ctl, 4'h3);
        pc_after("jp5_pc", 16'h0005);
        mem[16'h0005] = 16'hF012;
        run_word(c);
        chk("pre_cycles", c, 3);
        chk("pre_nissue", obs_op.size(), 0);
        chk("pre_ctl", obs_ctl, 4'h0);
        pc_after("pre_pc", 16'h0006);
        mem[16'h0006] = 16'hD834;
        run_word(c);
        chk("jpp_cimm", obs_cimm, 16'h1234);
        chk("jpp_ctl", obs_ctl, 4'h3);
        pc_after("jpp_pc", 16'h1234);

        // ci8 shows pre was cleared by the jump
        mem[16'h1234] = 16'hE9AB;
        run_word(c);
        chk("ci8_nissue", obs_imm.size(), 1);
        if (obs_imm.size() == 1) begin
            chk("ci8_op", obs_op[0], 5'h1D);
            chk("ci8_imm", obs_imm[0], 16'h00AB);
        end
        pc_after("ci8_pc", 16'h1235);

        // jz8 not taken
        regs[3] = 16'h0005;
        mem[16'h1235] = 16'hD340;
        run_word(c);
        chk("jz_rda", obs_rda, 3'd3);
        chk("jz_ctl", obs_ctl, 4'h1);
        pc_after("jz_pc", 16'h1236);

        // LO jr
        regs[4] = 16'h0ABC;
        mem[16'h1236] = 16'h0154;
        run_word(c);
        chk("lojr_cycles", c, 3);
        chk("lojr_nissue", obs_op.size(), 1);
        if (obs_op.size() == 1) begin
            chk("lojr_op", obs_op[0], 5'h00);
            chk("lojr_reg", obs_reg[0], 3'd1);
        end
        chk("lojr_ctl", obs_ctl, 4'hC);
        chk("lojr_rdb", obs_rdb, 3'd4);
        pc_after("lojr_pc", 16'h0ABC);

        // Stall three cycles, then sys
        mem[16'h0ABC] = 16'h210A;
        stall_left = 3;
        run_word(c);
        chk("stall_cycles", c, 7);
        pc_after("stall_pc", 16'h0ABD);
        mem[16'h0ABD] = 16'hF800;
        run_word(c);
        chk("sys_cycles", c, 2);
        @(posedge clk);
        #1;
        chk("sys_halted", halted, 1);
        chk("sys_req", imem_req, 0);
        repeat (5) step();

        // Reset while an instruction is being offered
        do_reset();
        mem[16'h0000] = 16'h210A;
        stall_left = 100;
        repeat (3) step();
        @(posedge clk);
        #1;
        chk("offer_valid", iss_valid, 1);
        do_reset();

        // HI jr, then wrap of pc from 0xFFFF
        regs[2] = 16'h0100;
        mem[16'h0000] = 16'h5200;
        run_word(c);
        chk("hijr_cycles", c, 3);
        chk("hijr_nissue", obs_op.size(), 0);
        chk("hijr_ctl", obs_ctl, 4'h8);
        chk("hijr_rda", obs_rda, 3'd2);
        pc_after("hijr_pc", 16'h0100);
        mem[16'h0100] = 16'hF0FF;
        run_word(c);
        mem[16'h0101] = 16'hD8FF;
        run_word(c);
        chk("jpff_cimm", obs_cimm, 16'hFFFF);
        pc_after("jpff_pc", 16'hFFFF);
        mem[16'hFFFF] = 16'h210A;
        run_word(c);
        chk("wrap_cycles", c, 4);
        pc_after("wrap_pc", 16'h0000);

        // Randomized runs against the model
        force_ack = 1'b0; force_ready = 1'b0;
        for (int r = 0; r < 6; r++) begin
            mem.delete();
            for (int i = 0; i < 8; i++)
                regs[i] = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
            do_reset();
            repeat (400) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
